// File: rtl/tdm_demux8.sv
// Receive end of an 8:1 TDM serial link: locks to frame sync, tracks the slot
// index and rebuilds the parallel word, with flywheel and slip recovery.
module tdm_demux8 #(
  parameter int unsigned N_CH     = 8,
  parameter int unsigned SEL_W    = 3,
  parameter int unsigned MAX_MISS = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             din,
  input  logic             fsync,
  output logic [SEL_W-1:0] S,
  output logic [N_CH-1:0]  Y,
  output logic             frame_valid,
  output logic             locked,
  output logic             sync_err
);

  localparam int unsigned MISS_W = $clog2(MAX_MISS + 1);

  typedef enum logic {HUNT, LOCK} state_t;

  state_t              state;
  logic [SEL_W-1:0]    slot;
  logic [N_CH-2:0]     shreg;
  logic [MISS_W-1:0]   miss_cnt;

  assign S = slot;

  // The last slot's bit goes straight into Y, so shreg only holds slots 0..N_CH-2.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= HUNT;
      slot        <= '0;
      shreg       <= '0;
      miss_cnt    <= '0;
      Y           <= '0;
      frame_valid <= 1'b0;
      locked      <= 1'b0;
      sync_err    <= 1'b0;
    end else begin
      frame_valid <= 1'b0;
      sync_err    <= 1'b0;
      if (en) begin
        case (state)
          HUNT: begin
            if (fsync) begin
              shreg[0] <= din;
              slot     <= SEL_W'(1);
              miss_cnt <= '0;
              state    <= LOCK;
              locked   <= 1'b1;
            end
          end
          LOCK: begin
            if (fsync && slot != '0) begin
              // Slip: restart the frame with this bit as slot 0.
              sync_err <= 1'b1;
              shreg[0] <= din;
              slot     <= SEL_W'(1);
              miss_cnt <= '0;
            end else if (slot == '0) begin
              if (fsync) begin
                shreg[0] <= din;
                slot     <= SEL_W'(1);
                miss_cnt <= '0;
              end else if (miss_cnt == MISS_W'(MAX_MISS - 1)) begin
                state    <= HUNT;
                locked   <= 1'b0;
                miss_cnt <= '0;
              end else begin
                shreg[0] <= din;
                slot     <= SEL_W'(1);
                miss_cnt <= miss_cnt + MISS_W'(1);
              end
            end else if (slot == SEL_W'(N_CH - 1)) begin
              Y           <= {din, shreg};
              frame_valid <= 1'b1;
              slot        <= '0;
            end else begin
              shreg[slot] <= din;
              slot        <= slot + SEL_W'(1);
            end
          end
          default: state <= HUNT;
        endcase
      end
    end
  end

endmodule
